// File: rtl/uart_byte_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_byte_tx : frames one byte per handshake onto the UART TX line       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_byte_tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 clk_bps,
   output logic                 bps_start,
   output logic                 uart_tx,
   output logic                 tx_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      PAR   = 3'd4,
      STOP  = 3'd5
   } state_t;

   localparam logic [2:0] c_last_bit  = 3'(DATA_BITS - 1);
   localparam logic       c_last_stop = 1'(STOP_BITS - 1);

   state_t                r_state, w_state_nx;
   logic [DATA_BITS-1:0]  r_shift, w_shift_nx;
   logic                  r_par, w_par_nx;
   logic [2:0]            r_bit_cnt, w_bit_cnt_nx;
   logic                  r_stop_cnt, w_stop_cnt_nx;
   logic                  r_tx, w_tx_nx;
   logic                  r_bps, w_bps_nx;
   logic                  r_done, w_done_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_bps      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_shift    <= w_shift_nx;
         r_par      <= w_par_nx;
         r_bit_cnt  <= w_bit_cnt_nx;
         r_stop_cnt <= w_stop_cnt_nx;
         r_tx       <= w_tx_nx;
         r_bps      <= w_bps_nx;
         r_done     <= w_done_nx;
      end
   end

   // Every line level is registered; the shifter always presents the next bit at [0].
   always_comb begin
      w_state_nx    = r_state;
      w_shift_nx    = r_shift;
      w_par_nx      = r_par;
      w_bit_cnt_nx  = r_bit_cnt;
      w_stop_cnt_nx = r_stop_cnt;
      w_tx_nx       = r_tx;
      w_bps_nx      = r_bps;
      w_done_nx     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_tx_nx = 1'b1;
            if (tx_valid) begin
               w_shift_nx = tx_data;
               w_par_nx   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
               w_bps_nx   = 1'b1;
               w_state_nx = WAIT;
            end
         end
         WAIT: begin
            if (clk_bps) begin
               w_tx_nx    = 1'b0;
               w_state_nx = START;
            end
         end
         START: begin
            if (clk_bps) begin
               w_tx_nx      = r_shift[0];
               w_shift_nx   = r_shift >> 1;
               w_bit_cnt_nx = '0;
               w_state_nx   = DATA;
            end
         end
         DATA: begin
            if (clk_bps) begin
               if (r_bit_cnt < c_last_bit) begin
                  w_tx_nx      = r_shift[0];
                  w_shift_nx   = r_shift >> 1;
                  w_bit_cnt_nx = r_bit_cnt + 3'd1;
               end else if (PARITY != 0) begin
                  w_tx_nx    = r_par;
                  w_state_nx = PAR;
               end else begin
                  w_tx_nx       = 1'b1;
                  w_stop_cnt_nx = 1'b0;
                  w_state_nx    = STOP;
               end
            end
         end
         PAR: begin
            if (clk_bps) begin
               w_tx_nx       = 1'b1;
               w_stop_cnt_nx = 1'b0;
               w_state_nx    = STOP;
            end
         end
         STOP: begin
            if (clk_bps) begin
               w_tx_nx = 1'b1;
               if (r_stop_cnt < c_last_stop) begin
                  w_stop_cnt_nx = r_stop_cnt + 1'b1;
               end else begin
                  w_bps_nx   = 1'b0;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end
            end
         end
         default: begin
            w_tx_nx    = 1'b1;
            w_bps_nx   = 1'b0;
            w_state_nx = IDLE;
         end
      endcase
   end

   assign tx_ready  = (r_state == IDLE);
   assign bps_start = r_bps;
   assign uart_tx   = r_tx;
   assign tx_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_byte_tx : scoreboard bench over 8N1 / 8E1 / 8O1 / 8N2 instances  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_byte_tx;

   localparam int NI        = 4;
   localparam int BPS_PARA  = 217;
   localparam int HALF      = 109;
   localparam int BIT       = 218;

   function automatic int par_of(input int i);
      return (i == 1) ? 1 : (i == 2) ? 2 : 0;
   endfunction
   function automatic int stop_of(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   typedef struct {
      int          inst;
      logic [15:0] bits;
      int          nbits;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NI-1:0][7:0]  tx_data;
   logic [NI-1:0]       tx_valid, tx_ready, clk_bps, bps_start, uart_tx, tx_done, extra_tick;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int          phase     [NI];
   int          mclk      [NI];
   int          since_bps [NI];
   logic [15:0] cap       [NI];
   logic        prev_tx   [NI];
   logic        prev_bps  [NI];

   always #20 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      int bcnt = 0;
      // Baud generator model: cleared while bps_start is low, first tick half a period in.
      always @(posedge clk) begin
         if (!bps_start[g])          bcnt <= 0;
         else if (bcnt == BPS_PARA)  bcnt <= 0;
         else                        bcnt <= bcnt + 1;
      end
      assign clk_bps[g] = (bps_start[g] && (bcnt == HALF - 1)) || extra_tick[g];

      uart_byte_tx #(
         .DATA_BITS (8),
         .PARITY    (par_of(g)),
         .STOP_BITS (stop_of(g))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .tx_data   (tx_data[g]),
         .tx_valid  (tx_valid[g]),
         .tx_ready  (tx_ready[g]),
         .clk_bps   (clk_bps[g]),
         .bps_start (bps_start[g]),
         .uart_tx   (uart_tx[g]),
         .tx_done   (tx_done[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   // Monitor: captures each frame at mid-bit and scores it when tx_done pulses.
   initial begin
      exp_t        e;
      logic [15:0] m;
      int          k;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
               phase[i]     = 0;
               prev_tx[i]   = 1'b1;
               prev_bps[i]  = 1'b0;
               since_bps[i] = 0;
            end else begin
               if (bps_start[i] && !prev_bps[i]) since_bps[i] = 0;
               else                              since_bps[i]++;
               if (phase[i] == 0) begin
                  if (prev_tx[i] && !uart_tx[i]) begin
                     check($sformatf("start_latency[%0d]", i), since_bps[i], HALF);
                     phase[i] = 1;
                     mclk[i]  = 0;
                     cap[i]   = '0;
                  end
               end else begin
                  mclk[i]++;
                  if (mclk[i] >= HALF && ((mclk[i] - HALF) % BIT) == 0) begin
                     k = (mclk[i] - HALF) / BIT;
                     if (k < 16) cap[i][k] = uart_tx[i];
                  end
               end
               if (tx_done[i]) begin
                  if (sb.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_done[%0d]: got tx_done, expected none (t=%0t)", i, $time);
                  end else begin
                     e = sb.pop_front();
                     m = 16'((32'd1 << e.nbits) - 1);
                     check($sformatf("done_inst[%0d]", i), i, e.inst);
                     check($sformatf("frame_bits[%0d]", i), 32'(cap[i] & m), 32'(e.bits));
                     check($sformatf("frame_clocks[%0d]", i), mclk[i], e.nbits * BIT);
                     check($sformatf("ready_at_done[%0d]", i), 32'(tx_ready[i]), 1);
                     check($sformatf("bps_at_done[%0d]", i), 32'(bps_start[i]), 0);
                  end
                  phase[i] = 0;
               end
               prev_tx[i]  = uart_tx[i];
               prev_bps[i] = bps_start[i];
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d, input logic [15:0] fr, input int nb,
                       input bit push, input bit hold, input bit tick_acc);
      int c;
      @(negedge clk);
      tx_data[i]  = d;
      tx_valid[i] = 1'b1;
      c = 0;
      while (!tx_ready[i] && c < 4000) begin
         @(negedge clk);
         c++;
      end
      if (!tx_ready[i]) timeout_fail($sformatf("accept[%0d]", i));
      if (tick_acc) extra_tick[i] = 1'b1;
      if (push) sb.push_back('{i, fr, nb});
      @(negedge clk);
      extra_tick[i] = 1'b0;
      if (!hold) tx_valid[i] = 1'b0;
      tx_data[i] = ~d;
      check($sformatf("busy_after_accept[%0d]", i), 32'(tx_ready[i]), 0);
      check($sformatf("bps_after_accept[%0d]", i), 32'(bps_start[i]), 1);
   endtask

   task automatic wait_done(input int i);
      int c;
      c = 0;
      while (!tx_done[i] && c < 5000) begin
         @(negedge clk);
         c++;
      end
      if (!tx_done[i]) timeout_fail($sformatf("tx_done[%0d]", i));
   endtask

   initial begin
      int t;
      int c;
      logic saw_done;
      tx_valid   = '0;
      tx_data    = '0;
      extra_tick = '0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_tx[%0d]", i), 32'(uart_tx[i]), 1);
         check($sformatf("rst_bps[%0d]", i), 32'(bps_start[i]), 0);
         check($sformatf("rst_done[%0d]", i), 32'(tx_done[i]), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check($sformatf("rst_ready[%0d]", i), 32'(tx_ready[i]), 1);

      // Stray ticks while idle must not move the line.
      for (int n = 0; n < 4; n++) begin
         @(negedge clk); extra_tick[1] = 1'b1;
         @(negedge clk); extra_tick[1] = 1'b0;
         check("idle_tick_tx", 32'(uart_tx[1]), 1);
         check("idle_tick_bps", 32'(bps_start[1]), 0);
      end

      send(0, 8'h55, 16'h02AA, 10, 1'b1, 1'b0, 1'b0);
      wait_done(0);
      @(negedge clk);
      check("ready_after_done", 32'(tx_ready[0]), 1);

      send(1, 8'h07, 16'h060E, 11, 1'b1, 1'b0, 1'b0);
      wait_done(1);
      send(2, 8'h03, 16'h0606, 11, 1'b1, 1'b0, 1'b1);
      wait_done(2);
      send(3, 8'hA3, 16'h0746, 11, 1'b1, 1'b0, 1'b0);
      wait_done(3);

      // Back-to-back with tx_valid held and tx_data disturbed mid-frame.
      send(0, 8'h12, 16'h0224, 10, 1'b1, 1'b1, 1'b0);
      tx_data[0] = 8'hC9;
      repeat (700) @(negedge clk);
      tx_data[0] = 8'h34;
      sb.push_back('{0, 16'h0268, 10});
      wait_done(0);
      check("b2b_bps_low", 32'(bps_start[0]), 0);
      check("b2b_ready_at_done", 32'(tx_ready[0]), 1);
      @(negedge clk);
      check("b2b_bps_relaunch", 32'(bps_start[0]), 1);
      check("b2b_reaccept", 32'(tx_ready[0]), 0);
      tx_valid[0] = 1'b0;
      tx_data[0]  = 8'h00;
      wait_done(0);

      // Reset after tick 5 of a 0xA5 frame: line is carrying data bit 3 (0).
      send(0, 8'hA5, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
      t = 0;
      c = 0;
      while (t < 5 && c < 3000) begin
         @(negedge clk);
         c++;
         if (clk_bps[0]) t++;
      end
      if (t < 5) timeout_fail("tick5");
      @(negedge clk);
      check("mid_frame_bit3", 32'(uart_tx[0]), 0);
      rst_n = 1'b0;
      #1;
      check("abort_tx", 32'(uart_tx[0]), 1);
      check("abort_bps", 32'(bps_start[0]), 0);
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_done = saw_done | tx_done[0];
      end
      check("abort_no_done", 32'(saw_done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", 32'(tx_ready[0]), 1);

      send(0, 8'hFF, 16'h03FE, 10, 1'b1, 1'b0, 1'b0);
      wait_done(0);
      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- UART transmitter that serialises one byte per frame onto the serial TX line.
- Pairs with the shared baud-tick generator: this block asserts bps_start for the duration of a frame and advances one bit per clk_bps pulse.
- Sits between the display/sound data path (byte source with valid/ready handshake) and the board UART pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock (25 MHz).
- rst_n  input  1  asynchronous reset, active low.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready on a rising clk edge.
- clk_bps  input  1  one-cycle baud tick from the baud generator.
- bps_start  output  1  enables the baud generator; low clears its counter.
- uart_tx  output  1  serial line, idle high.
- tx_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- One clock domain; every flop is reset asynchronously by rst_n low.
- Reset values: uart_tx = 1, bps_start = 0, tx_done = 0, state = IDLE, tx_ready = 1 once reset is released.
- States: IDLE, WAIT, START, DATA, PAR, STOP. All transitions out of WAIT and later states happen only on a cycle where clk_bps = 1.
- IDLE:
  - tx_ready = 1; clk_bps is ignored.
  - On accept: latch tx_data into the shift register, compute the parity bit (even = XOR of the data bits, odd = its inverse), set bps_start = 1 and go to WAIT.
  - uart_tx stays 1.
- WAIT, on tick: uart_tx <= 0 (start bit), go to START.
- START, on tick: uart_tx <= data bit 0, bit counter = 0, go to DATA.
- DATA, on tick:
  - If the bit counter is below DATA_BITS-1: drive the next data bit and increment the counter.
  - Otherwise: if PARITY != 0, drive the parity bit and go to PAR; else drive 1 and go to STOP with the stop counter at 0.
- PAR, on tick: uart_tx <= 1, go to STOP with the stop counter at 0.
- STOP, on tick:
  - If the stop counter is below STOP_BITS-1: increment the counter and keep uart_tx at 1.
  - Otherwise: bps_start <= 0, tx_done <= 1 for one cycle, go to IDLE.
- Timing:
  - Each line level is held from one tick to the next, i.e. one bit period.
  - A frame consumes 2 + DATA_BITS + (PARITY != 0) + STOP_BITS ticks, which is 11 ticks for 8N1.
- tx_ready is low from the cycle after accept until the cycle after tx_done.
- tx_valid while busy is ignored: no accept, no corruption of the latched data.
- tx_data changes after accept have no effect.
- Back-to-back frames:
  - The earliest re-accept is the cycle after tx_done, so bps_start is guaranteed low for at least one cycle.
  - That low cycle restarts the baud generator counter, and the first tick of the new frame arrives a half period later.
- A tick coinciding with accept (state IDLE) is ignored.
- Reset mid-frame: the line returns to 1 immediately and bps_start goes to 0; the partial frame is abandoned with no tx_done.
- The output is registered, so uart_tx never glitches.

Test Plan:
- 8N1, tx_data = 0x55, with a bench tick every 218 clocks (BPS_PARA = 217) and the first tick 109 clocks after bps_start rises.
  - Required: uart_tx holds 1 until tick 1, then each level is held 218 clocks: 0,1,0,1,0,1,0,1,0,1.
  - Required: bps_start falls and tx_done pulses exactly once on tick 11, then tx_ready = 1.
- PARITY = 1, tx_data = 0x07 (three ones): parity bit = 1 follows data bit 7, frame is 12 ticks.
- PARITY = 2, tx_data = 0x03: parity bit = 1.
- STOP_BITS = 2, tx_data = 0xA3: data bits 1,1,0,0,0,1,0,1, then line high for 2 ticks, tx_done on tick 12.
- Back-to-back 0x12 then 0x34 with tx_valid held high:
  - Required: the second accept happens on the cycle after tx_done, and bps_start is low for exactly 1 cycle between frames.
  - Required: both frames are bit-exact, and tx_data changes during frame 1 are ignored.
- Robustness:
  - clk_bps pulses in IDLE leave uart_tx = 1.
  - rst_n low at tick 5 of a frame forces uart_tx = 1, bps_start = 0, no tx_done.
  - After reset release, a new 0xFF frame is sent correctly.
